// File: rtl/stream_capture_pkg.sv
// Shared types and defaults for the stream capture sink.
package stream_capture_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 1024;
  localparam int CSUM_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/stream_capture_sink_if.sv
// Avalon-ST beat channel: the source drives data/valid and the sink returns ready (readyLatency = 1).
interface stream_capture_sink_if #(
  parameter int DATA_W = 16
);

  logic [DATA_W-1:0] data_in;
  logic              valid;
  logic              ready;

  modport master (
    output data_in,
    output valid,
    input  ready
  );

  modport slave (
    input  data_in,
    input  valid,
    output ready
  );

endinterface

// File: rtl/capture_ram.sv
// Capture memory: one write port and one registered read port; a same-address read returns old data.
module capture_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array is deliberately left out of reset so captured data survives it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/stream_capture_sink.sv
// Stream sink: grants up to target_len credits, stores accepted beats, tracks count and checksum.
// ready is combinational; a beat lands one cycle after its credit and is always accepted.
module stream_capture_sink
  import stream_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk_hifreq,
  input  logic                  rst,
  stream_capture_sink_if.slave  st,
  input  logic                  start,
  input  logic [ADDR_W:0]       target_len,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W:0]       word_count,
  output logic [CSUM_W-1:0]     checksum,
  output logic                  proto_err
);

  state_t          state_q;
  state_t          state_d;
  logic [ADDR_W:0] target_q;
  logic [ADDR_W:0] credits_q;
  logic            ready_q;
  logic            ready_int;
  logic            arm;
  logic            accept;
  logic            last_beat;
  logic            mem_we;

  // Abort withdraws credit in the same cycle so no further beat is owed after it.
  always_comb begin
    ready_int = 1'b0;
    if (state_q == CAPTURE && credits_q < target_q && !abort) begin
      ready_int = 1'b1;
    end
  end

  assign st.ready = ready_int;

  assign arm       = start && (state_q == IDLE || state_q == DONE);
  assign accept    = st.valid && ready_q && !arm;
  assign last_beat = accept && ((word_count + 1'b1) == target_q);
  assign mem_we    = accept && rst;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          state_d = (target_len == '0) ? DONE : CAPTURE;
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_d = DRAIN;
        end else if (last_beat) begin
          state_d = DONE;
        end
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_hifreq) begin
    if (!rst) begin
      state_q    <= IDLE;
      target_q   <= '0;
      credits_q  <= '0;
      ready_q    <= 1'b0;
      word_count <= '0;
      checksum   <= '0;
      proto_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_int;
      if (arm) begin
        target_q   <= target_len;
        credits_q  <= '0;
        word_count <= '0;
        checksum   <= '0;
        proto_err  <= 1'b0;
      end else begin
        if (ready_int) begin
          credits_q <= credits_q + 1'b1;
        end
        if (accept) begin
          word_count <= word_count + 1'b1;
          checksum   <= checksum + CSUM_W'(st.data_in);
        end
        // A beat with no credit from the prior cycle is a source violation; the word is dropped.
        if (st.valid && !ready_q) begin
          proto_err <= 1'b1;
        end
      end
    end
  end

  assign busy = (state_q == CAPTURE) || (state_q == DRAIN);
  assign done = (state_q == DONE);

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk_hifreq),
    .rst   (rst),
    .we    (mem_we),
    .waddr (word_count[ADDR_W-1:0]),
    .wdata (st.data_in),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_stream_capture_sink.sv
// Bench for stream_capture_sink: directed and randomized capture runs checked against a word-list model.
module tb_stream_capture_sink;
  import stream_capture_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [AW:0]   target_len;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic [AW:0]   word_count;
  logic [15:0]   checksum;
  logic          proto_err;

  int total = 0;
  int bad   = 0;
  logic [15:0] words[$];

  always #5 clk = ~clk;

  stream_capture_sink_if #(.DATA_W(DW)) st ();

  stream_capture_sink #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .ADDR_W (AW)
  ) dut (
    .clk_hifreq (clk),
    .rst        (rst),
    .st         (st.slave),
    .start      (start),
    .target_len (target_len),
    .abort      (abort),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .word_count (word_count),
    .checksum   (checksum),
    .proto_err  (proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(16'($urandom));
  endtask

  // One capture run: the bench plays a well-behaved source answering each ready one cycle later.
  task automatic run(input string name, input int tlen, input int abort_at, input int rst_after);
    int          rcnt, sent, ecnt, last_c, abort_c, done_c, exp_done_c;
    bit          pend, fin, aborted, did_rst, stray;
    logic [15:0] esum;
    ecnt = (abort_at >= 0 && abort_at < tlen) ? abort_at : tlen;
    esum = 16'h0;
    for (int i = 0; i < ecnt; i++) esum = esum + words[i];
    start      = 1'b1;
    target_len = tlen[AW:0];
    tick();
    start = 1'b0;
    rcnt = 0; sent = 0; pend = 1'b0; fin = 1'b0; aborted = 1'b0; did_rst = 1'b0;
    last_c = -1; abort_c = -1; done_c = -1;
    for (int c = 0; c < 3 * tlen + 20 && !fin; c++) begin
      if (done) begin
        fin    = 1'b1;
        done_c = c;
      end else begin
        st.valid   = pend;
        st.data_in = pend ? words[sent] : 16'($urandom);
        if (pend && rst_after >= 0 && sent == rst_after) begin
          rst     = 1'b0;
          did_rst = 1'b1;
        end else if (pend) begin
          sent++;
          last_c = c;
        end
        if (abort_at >= 0 && !aborted && rcnt == abort_at) begin
          abort   = 1'b1;
          aborted = 1'b1;
          abort_c = c;
        end
        #1;
        if (st.ready) rcnt++;
        pend = st.ready;
        tick();
        rst      = 1'b1;
        abort    = 1'b0;
        st.valid = 1'b0;
        if (did_rst) fin = 1'b1;
      end
    end
    if (did_rst) begin
      chk({name, ":rst_ready"}, 32'(st.ready), 32'd0);
      chk({name, ":rst_count"}, 32'(word_count), 32'd0);
      chk({name, ":rst_csum"}, 32'(checksum), 32'd0);
      chk({name, ":rst_busy"}, 32'(busy), 32'd0);
      chk({name, ":rst_done"}, 32'(done), 32'd0);
      chk({name, ":rst_rddata"}, 32'(rd_data), 32'd0);
      tick();
      chk({name, ":rst_perr"}, 32'(proto_err), 32'd0);
      chk({name, ":rst_idle_ready"}, 32'(st.ready), 32'd0);
      return;
    end
    chk({name, ":finished"}, 32'(fin), 32'd1);
    if (tlen == 0)        exp_done_c = 0;
    else if (abort_c >= 0) exp_done_c = abort_c + 2;
    else                  exp_done_c = last_c + 1;
    chk({name, ":done_cycle"}, 32'(done_c), 32'(exp_done_c));
    chk({name, ":ready_cycles"}, 32'(rcnt), 32'(ecnt));
    chk({name, ":word_count"}, 32'(word_count), 32'(ecnt));
    chk({name, ":checksum"}, 32'(checksum), 32'(esum));
    chk({name, ":done"}, 32'(done), 32'd1);
    chk({name, ":busy"}, 32'(busy), 32'd0);
    chk({name, ":proto_err"}, 32'(proto_err), 32'd0);
    stray = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (st.ready) stray = 1'b1;
      tick();
    end
    chk({name, ":ready_after"}, 32'(stray), 32'd0);
    for (int i = 0; i < ecnt; i++) begin
      rd_addr = i[AW-1:0];
      tick();
      chk({name, ":readback"}, 32'(rd_data), 32'(words[i]));
    end
  endtask

  initial begin
    int n;
    rst        = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    target_len = '0;
    rd_addr    = '0;
    st.valid   = 1'b0;
    st.data_in = '0;
    repeat (3) tick();
    chk("reset_ready", 32'(st.ready), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_count", 32'(word_count), 32'd0);
    chk("reset_csum", 32'(checksum), 32'd0);
    chk("reset_perr", 32'(proto_err), 32'd0);
    chk("reset_rddata", 32'(rd_data), 32'd0);
    rst = 1'b1;
    tick();

    words = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    run("basic4", 4, -1, -1);

    words = '{16'hFFFF, 16'h0003};
    run("wrap2", 2, -1, -1);

    // Beat with no credit while DONE: flagged, dropped, mem[0] keeps 0xFFFF.
    st.valid   = 1'b1;
    st.data_in = 16'h1234;
    rd_addr    = '0;
    tick();
    st.valid = 1'b0;
    chk("perr_set", 32'(proto_err), 32'd1);
    chk("perr_count", 32'(word_count), 32'd2);
    chk("perr_csum", 32'(checksum), 32'h0002);
    tick();
    chk("perr_nowrite", 32'(rd_data), 32'h0000FFFF);

    fill_random(10);
    run("abort10", 10, 3, -1);

    fill_random(8);
    run("reset8", 8, -1, 5);

    words.delete();
    run("zero", 0, -1, -1);
    fill_random(1);
    run("one", 1, -1, -1);

    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 40);
      fill_random(n);
      run("rand", n, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1, -1);
    end

    fill_random(DEPTH);
    run("full", DEPTH, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
